// File: rtl/mmio_stat_responder_if.sv
// MMIO read request/response bundle between the CCI-P host side and the
// status/performance register responder.
interface mmio_stat_responder_if;
   logic        mmio_rd_valid;
   logic [15:0] mmio_rd_addr;
   logic [1:0]  mmio_rd_len;
   logic [8:0]  mmio_rd_tid;
   logic        rsp_valid;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;

   modport master (
      output mmio_rd_valid,
      output mmio_rd_addr,
      output mmio_rd_len,
      output mmio_rd_tid,
      input  rsp_valid,
      input  rsp_tid,
      input  rsp_data
   );

   modport slave (
      input  mmio_rd_valid,
      input  mmio_rd_addr,
      input  mmio_rd_len,
      input  mmio_rd_tid,
      output rsp_valid,
      output rsp_tid,
      output rsp_data
   );
endinterface

// File: rtl/mmio_stat_responder.sv
// Two-stage MMIO read responder for the AES AFU status/performance registers:
// saturating line/cycle counters, run tracking and a constant ID register.
module mmio_stat_responder #(
   parameter logic [15:0] BASE_DW_ADDR = 16'h0040,
   parameter logic [63:0] ID_VALUE     = 64'h4145_535F_5354_4154
) (
   input logic                  clk,
   input logic                  reset,
   mmio_stat_responder_if.slave mmio,
   input logic                  run_start,
   input logic                  run_done,
   input logic                  rd_line_evt,
   input logic                  wr_line_evt
);

   localparam logic [63:0] CNT_MAX = {64{1'b1}};

   typedef enum logic {
      RUN_IDLE,
      RUN_BUSY
   } run_state_e;

   run_state_e  state;
   run_state_e  state_next;
   logic        busy;
   logic        done_ok;
   logic        done_sticky;
   logic [63:0] rd_lines;
   logic [63:0] wr_lines;
   logic [63:0] run_cycles;
   logic [63:0] last_run_cycles;

   logic        req_hit;
   logic [2:0]  req_idx;
   logic        s1_valid;
   logic [8:0]  s1_tid;
   logic [2:0]  s1_idx;
   logic        s1_len8;
   logic        s1_upper;
   logic        s1_hit;
   logic [63:0] sel_reg;
   logic [63:0] fmt_data;

   function automatic logic [63:0] sat_inc(input logic [63:0] v);
      sat_inc = (v == CNT_MAX) ? v : v + 64'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= RUN_IDLE;
      else       state <= state_next;
   end

   // A start always (re)enters BUSY, even when it coincides with done.
   always_comb begin
      state_next = state;
      case (state)
         RUN_IDLE: if (run_start) state_next = RUN_BUSY;
         RUN_BUSY: begin
            if (run_start)     state_next = RUN_BUSY;
            else if (run_done) state_next = RUN_IDLE;
         end
         default:  state_next = RUN_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN_BUSY);
   end

   assign done_ok = run_done && busy;

   always_ff @(posedge clk) begin
      if (reset)          done_sticky <= 1'b0;
      else if (run_start) done_sticky <= 1'b0;
      else if (done_ok)   done_sticky <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)        last_run_cycles <= 64'd0;
      else if (done_ok) last_run_cycles <= sat_inc(run_cycles);
   end

   always_ff @(posedge clk) begin
      if (reset)          run_cycles <= 64'd0;
      else if (run_start) run_cycles <= 64'd0;
      else if (busy)      run_cycles <= sat_inc(run_cycles);
   end

   // Line events coinciding with run_start are deliberately lost in the clear.
   always_ff @(posedge clk) begin
      if (reset)            rd_lines <= 64'd0;
      else if (run_start)   rd_lines <= 64'd0;
      else if (rd_line_evt) rd_lines <= sat_inc(rd_lines);
   end

   always_ff @(posedge clk) begin
      if (reset)            wr_lines <= 64'd0;
      else if (run_start)   wr_lines <= 64'd0;
      else if (wr_line_evt) wr_lines <= sat_inc(wr_lines);
   end

   assign req_hit = ({1'b0, mmio.mmio_rd_addr} >= {1'b0, BASE_DW_ADDR}) &&
                    ({1'b0, mmio.mmio_rd_addr} <  ({1'b0, BASE_DW_ADDR} + 17'd12));
   assign req_idx = 3'((mmio.mmio_rd_addr - BASE_DW_ADDR) >> 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_tid   <= 9'd0;
         s1_idx   <= 3'd0;
         s1_len8  <= 1'b0;
         s1_upper <= 1'b0;
         s1_hit   <= 1'b0;
      end else begin
         s1_valid <= mmio.mmio_rd_valid;
         s1_tid   <= mmio.mmio_rd_tid;
         s1_idx   <= req_idx;
         s1_len8  <= |mmio.mmio_rd_len;
         s1_upper <= mmio.mmio_rd_addr[0];
         s1_hit   <= req_hit;
      end
   end

   // Whole register is selected in one cycle, so 64-bit reads never tear.
   always_comb begin
      sel_reg = 64'd0;
      if (s1_hit) begin
         case (s1_idx)
            3'd0:    sel_reg = {62'd0, busy, done_sticky};
            3'd1:    sel_reg = rd_lines;
            3'd2:    sel_reg = wr_lines;
            3'd3:    sel_reg = run_cycles;
            3'd4:    sel_reg = last_run_cycles;
            3'd5:    sel_reg = ID_VALUE;
            default: sel_reg = 64'd0;
         endcase
      end
   end

   always_comb begin
      fmt_data = sel_reg;
      if (!s1_len8) fmt_data = {32'd0, s1_upper ? sel_reg[63:32] : sel_reg[31:0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mmio.rsp_valid <= 1'b0;
         mmio.rsp_tid   <= 9'd0;
         mmio.rsp_data  <= 64'd0;
      end else begin
         mmio.rsp_valid <= s1_valid;
         if (s1_valid) begin
            mmio.rsp_tid  <= s1_tid;
            mmio.rsp_data <= fmt_data;
         end
      end
   end

endmodule

// File: tb/tb_mmio_stat_responder.sv
// Self-checking bench for mmio_stat_responder: directed vector table, corner
// sequences and random traffic scored against a register-level model.
module tb_mmio_stat_responder;

   localparam logic [15:0] BASE    = 16'h0040;
   localparam logic [63:0] ID      = 64'h4145_535F_5354_4154;
   localparam logic [63:0] CNT_MAX = {64{1'b1}};

   logic clk = 1'b0;
   logic reset;
   logic run_start;
   logic run_done;
   logic rd_line_evt;
   logic wr_line_evt;

   mmio_stat_responder_if bus();

   mmio_stat_responder #(
      .BASE_DW_ADDR(BASE),
      .ID_VALUE(ID)
   ) dut (
      .clk(clk),
      .reset(reset),
      .mmio(bus),
      .run_start(run_start),
      .run_done(run_done),
      .rd_line_evt(rd_line_evt),
      .wr_line_evt(wr_line_evt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [8:0]  tid;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [1:0]  len;
      logic [63:0] exp;
   } vec_t;

   exp_t        exp_q[$];
   logic [63:0] rx_data[$];
   vec_t        tab[12];
   int          cyc    = 0;
   int          total  = 0;
   int          passed = 0;

   logic [63:0] m_rd, m_wr, m_rc, m_last;
   logic        m_busy, m_done;

   function automatic logic [63:0] sat_inc(input logic [63:0] v);
      return (v == CNT_MAX) ? v : v + 64'd1;
   endfunction

   function automatic logic [63:0] model_read(input logic [15:0] addr, input logic [1:0] len);
      logic [63:0] r;
      int k;
      if (addr < BASE || addr >= BASE + 16'd12) return 64'd0;
      k = int'(addr - BASE) / 2;
      case (k)
         0: r = {62'd0, m_busy, m_done};
         1: r = m_rd;
         2: r = m_wr;
         3: r = m_rc;
         4: r = m_last;
         default: r = ID;
      endcase
      if (len == 2'd0) return addr[0] ? {32'd0, r[63:32]} : {32'd0, r[31:0]};
      return r;
   endfunction

   // Done effects are applied before start effects when both arrive together.
   task automatic model_step(input logic rst, input logic st, input logic dn,
                             input logic rde, input logic wre);
      logic was_busy;
      if (rst) begin
         m_rd = 0; m_wr = 0; m_rc = 0; m_last = 0; m_busy = 0; m_done = 0;
         return;
      end
      was_busy = m_busy;
      if (dn && was_busy) begin
         m_last = sat_inc(m_rc);
         m_busy = 1'b0;
         m_done = 1'b1;
      end
      if (st) begin
         m_rd = 0; m_wr = 0; m_rc = 0; m_busy = 1'b1; m_done = 1'b0;
      end else begin
         if (rde)      m_rd = sat_inc(m_rd);
         if (wre)      m_wr = sat_inc(m_wr);
         if (was_busy) m_rc = sat_inc(m_rc);
      end
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic check_rx(input string name, input int i, input logic [63:0] exp);
      if (i < rx_data.size()) check(name, rx_data[i], exp);
      else begin
         total++;
         $display("[TB] FAIL %s: got no response expected %h", name, exp);
      end
   endtask

   task automatic check_output();
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
         check("rsp_tid", 64'(bus.rsp_tid), 64'(e.tid));
         check("rsp_data", bus.rsp_data, e.data);
         rx_data.push_back(bus.rsp_data);
      end else begin
         check("rsp_valid idle", 64'(bus.rsp_valid), 64'd0);
      end
   endtask

   task automatic apply_stimulus(input logic rst, input logic st, input logic dn,
                                 input logic rde, input logic wre, input logic rv,
                                 input logic [15:0] addr, input logic [1:0] len,
                                 input logic [8:0] tid);
      reset             = rst;
      run_start         = st;
      run_done          = dn;
      rd_line_evt       = rde;
      wr_line_evt       = wre;
      bus.mmio_rd_valid = rv;
      bus.mmio_rd_addr  = addr;
      bus.mmio_rd_len   = len;
      bus.mmio_rd_tid   = tid;
      @(posedge clk);
      model_step(rst, st, dn, rde, wre);
      cyc++;
      if (rst) exp_q.delete();
      else if (rv) exp_q.push_back('{cyc + 1, tid, model_read(addr, len)});
      #1;
      check_output();
   endtask

   task automatic idle_cycle();
      apply_stimulus(0, 0, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
   endtask

   task automatic issue_read(input logic [15:0] addr, input logic [1:0] len, input logic [8:0] tid);
      apply_stimulus(0, 0, 0, 0, 0, 1, addr, len, tid);
   endtask

   initial begin
      tab[0]  = '{16'h0048, 2'd1, 64'd11};
      tab[1]  = '{16'h0040, 2'd1, 64'd1};
      tab[2]  = '{16'h004A, 2'd0, 64'h0000_0000_5354_4154};
      tab[3]  = '{16'h004B, 2'd0, 64'h0000_0000_4145_535F};
      tab[4]  = '{16'h0100, 2'd1, 64'd0};
      tab[5]  = '{16'h0046, 2'd1, 64'd11};
      tab[6]  = '{16'h0049, 2'd1, 64'd11};
      tab[7]  = '{16'h004C, 2'd1, 64'd0};
      tab[8]  = '{16'h003F, 2'd0, 64'd0};
      tab[9]  = '{16'h004A, 2'd2, ID};
      tab[10] = '{16'h004B, 2'd3, ID};
      tab[11] = '{16'h0049, 2'd0, 64'd0};

      apply_stimulus(1, 0, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      apply_stimulus(1, 0, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset rsp_tid", 64'(bus.rsp_tid), 64'd0);
      check("reset rsp_data", bus.rsp_data, 64'd0);

      rx_data.delete();
      issue_read(16'h004A, 2'd1, 9'h1A5);
      repeat (3) idle_cycle();
      check("id read count", 64'(rx_data.size()), 64'd1);
      check_rx("id read data", 0, ID);

      apply_stimulus(0, 1, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      repeat (10) idle_cycle();
      apply_stimulus(0, 0, 1, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      rx_data.delete();
      for (int i = 0; i < 12; i++) issue_read(tab[i].addr, tab[i].len, 9'(i * 37 + 5));
      repeat (3) idle_cycle();
      check("table count", 64'(rx_data.size()), 64'd12);
      for (int i = 0; i < 12; i++) check_rx($sformatf("table[%0d]", i), i, tab[i].exp);

      apply_stimulus(0, 1, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, (i < 2), 0, 16'd0, 2'd0, 9'd0);
      apply_stimulus(0, 1, 1, 1, 1, 0, 16'd0, 2'd0, 9'd0);
      for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 1, (i < 2), 0, 16'd0, 2'd0, 9'd0);
      rx_data.delete();
      issue_read(16'h0042, 2'd1, 9'h011);
      issue_read(16'h0044, 2'd1, 9'h012);
      issue_read(16'h0048, 2'd1, 9'h013);
      issue_read(16'h0040, 2'd1, 9'h014);
      repeat (3) idle_cycle();
      check_rx("restart rd_lines", 0, 64'd3);
      check_rx("restart wr_lines", 1, 64'd2);
      check_rx("restart last_run", 2, 64'd4);
      check_rx("restart status", 3, 64'd2);

      force dut.rd_lines = 64'hFFFF_FFFF_FFFF_FFFE;
      idle_cycle();
      release dut.rd_lines;
      m_rd = 64'hFFFF_FFFF_FFFF_FFFE;
      repeat (3) apply_stimulus(0, 0, 0, 1, 0, 0, 16'd0, 2'd0, 9'd0);
      rx_data.delete();
      issue_read(16'h0042, 2'd1, 9'h0F0);
      issue_read(16'h0043, 2'd0, 9'h0F1);
      repeat (3) idle_cycle();
      check_rx("saturated rd_lines", 0, CNT_MAX);
      check_rx("saturated rd_lines hi", 1, 64'h0000_0000_FFFF_FFFF);

      rx_data.delete();
      issue_read(16'h004A, 2'd1, 9'h0AB);
      apply_stimulus(1, 0, 0, 0, 0, 0, 16'd0, 2'd0, 9'd0);
      repeat (2) idle_cycle();
      check("dropped by reset", 64'(rx_data.size()), 64'd0);
      for (int i = 0; i < 6; i++) issue_read(16'(BASE + 16'(2 * i)), 2'd1, 9'(i + 1));
      repeat (3) idle_cycle();
      for (int i = 0; i < 6; i++)
         check_rx($sformatf("post-reset reg%0d", i), i, (i == 5) ? ID : 64'd0);

      for (int n = 0; n < 800; n++) begin
         apply_stimulus($urandom_range(0, 199) == 0,
                        $urandom_range(0, 39) == 0,
                        $urandom_range(0, 29) == 0,
                        $urandom_range(0, 2) == 0,
                        $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1) == 0,
                        16'($urandom_range(16'h003C, 16'h0050)),
                        2'($urandom_range(0, 3)),
                        9'($urandom));
      end
      repeat (3) idle_cycle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
